if_stage_pc_ctrl: RTL and testbench
===================================

// Module: if_stage_pc_ctrl
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipelined MIPS CPU: PC register, next-PC select, IF/ID pipeline register.
//  Consumes the hazard unit's stall outputs (PCWrite_HD, IF_ID_write) and the branch/jump redirects from ID/EXE.
//  Latches the halt opcode (6'b111111) into a sticky HALTED state that freezes fetch.
//  Keeps saturating cycle and stall counters for the debug display.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on Reset
//  HALT_OP   6'b111111      opcode that halts fetch when decoded in ID
//  CNT_W     16             width of cycle_cnt / stall_cnt
// PORTS
//  CLK            in   1      clock; all state updates on the rising edge
//  Reset          in   1      synchronous, active-high
//  PCWrite_HD     in   1      0 = hold PC (hazard stall)
//  IF_ID_write    in   1      0 = hold IF/ID register (hazard stall)
//  branch_taken   in   1      branch resolved taken in EXE (older instruction)
//  branch_target  in   32     target address for branch_taken
//  jump           in   1      jump decoded in ID
//  jump_target    in   32     target address for jump
//  imem_instr     in   32     instruction word at address pc (combinational IMEM read)
//  pc             out  32     current fetch address, driven to IMEM
//  IF_ID_pc4      out  32     registered pc+4 of the fetched instruction
//  IF_ID_instr    out  32     registered instruction; 32'h0 (NOP) when bubbled
//  IF_ID_valid    out  1      1 = IF_ID_instr is a real instruction
//  halted         out  1      1 = HALTED state (sticky until Reset)
//  cycle_cnt      out  CNT_W  cycles spent in RUN, saturating
//  stall_cnt      out  CNT_W  stall cycles in RUN, saturating
// BEHAVIOUR
//  Reset values (synchronous): pc=RESET_PC, IF_ID_pc4=0, IF_ID_instr=0, IF_ID_valid=0, halted=0, both counters 0; state=RUN.
//  FSM: RUN -> HALTED when IF_ID_valid && IF_ID_instr[31:26]==HALT_OP && !branch_taken. HALTED -> RUN only on Reset.
//  Priority in RUN, one decision per cycle: Reset > branch_taken > jump > stall > normal.
//   branch_taken: pc<=branch_target; IF/ID<=bubble (instr=0, valid=0, pc4=0). Overrides PCWrite_HD/IF_ID_write.
//   jump (no branch_taken): pc<=jump_target; IF/ID<=bubble. Overrides stall.
//   stall: PCWrite_HD=0 holds pc; IF_ID_write=0 holds all IF/ID fields. The two enables are independent.
//   normal: pc<=pc+4; IF_ID_instr<=imem_instr; IF_ID_pc4<=pc+4; IF_ID_valid<=1.
//  Redirect targets: bits [1:0] are forced to 0 on load; pc[1:0] is always 2'b00.
//  pc+4 is computed modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
//  Halt in the same cycle as branch_taken: the halt instruction is squashed, state stays RUN, branch is taken.
//  Halt in the same cycle as jump: HALTED wins; pc and IF/ID freeze (the halt in ID is older than nothing upstream).
//  HALTED: pc, IF/ID and both counters hold; all inputs except Reset are ignored.
//  Transition cycle into HALTED: registers already freeze on that edge (no extra fetch); halted=1 from the next cycle.
//  cycle_cnt +1 every RUN cycle; stall_cnt +1 on RUN cycles with IF_ID_write==0 and no redirect. Both saturate at all-ones.
//  Zero combinational paths from inputs to outputs; all outputs are registered.
//  Reset asserted mid-stall, mid-redirect or in HALTED: all state returns to reset values on that edge.
// TESTING
//  1. Reset, then 4 free cycles with imem = A,B,C,D -> pc = 0,4,8,C,10; IF_ID_instr = A..D; IF_ID_pc4 = 4..10; valid=1.
//  2. PCWrite_HD=0, IF_ID_write=0 for 2 cycles at pc=8 -> pc and IF/ID hold; stall_cnt=2; fetch resumes at 8.
//  3. branch_taken=1, target=32'h40, with stall and jump also asserted -> pc=40, IF/ID bubble (valid=0, instr=0).
//  4. jump, jump_target=32'h103 -> pc=32'h100 (low bits cleared); IF/ID bubble; stall_cnt unchanged.
//  5. Fetch 32'hFC00_0000 (op 111111) -> halted=1; pc, IF/ID, counters frozen for 10 cycles; Reset -> pc=RESET_PC, halted=0.
//  6. Halt in ID with branch_taken in same cycle -> no halt, pc=target; separately pc=32'hFFFF_FFFC free-runs -> pc=0.

Source files
------------

// File: rtl/if_stage_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_pc_ctrl
//  Purpose  : Instruction-fetch stage: PC register, next-PC select, IF/ID
//             pipeline register, sticky halt and saturating debug counters.
//  Revision : 1.0  initial release
// ============================================================================
module if_stage_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWrite_HD,
    input  logic             IF_ID_write,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc,
    output logic [31:0]      IF_ID_pc4,
    output logic [31:0]      IF_ID_instr,
    output logic             IF_ID_valid,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      c_align   = 32'hFFFF_FFFC;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pc4;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_stall;

    logic [31:0]      w_pc_plus4;
    logic             w_halt_hit;

    // Wraps naturally modulo 2^32.
    assign w_pc_plus4 = r_pc + 32'd4;

    // A taken branch is older than the halt sitting in ID, so it squashes it.
    assign w_halt_hit = r_valid && (r_instr[31:26] == HALT_OP) && !branch_taken;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_pc4   <= 32'h0;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_cycle <= '0;
            r_stall <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_cycle != c_cnt_max) begin
                r_cycle <= r_cycle + c_cnt_one;
            end
            if (branch_taken) begin
                r_pc    <= branch_target & c_align;
                r_pc4   <= 32'h0;
                r_instr <= 32'h0;
                r_valid <= 1'b0;
            end else if (w_halt_hit) begin
                // Fetch state freezes on this very edge; no extra fetch.
                r_state <= ST_HALTED;
            end else if (jump) begin
                r_pc    <= jump_target & c_align;
                r_pc4   <= 32'h0;
                r_instr <= 32'h0;
                r_valid <= 1'b0;
            end else begin
                if (!IF_ID_write && (r_stall != c_cnt_max)) begin
                    r_stall <= r_stall + c_cnt_one;
                end
                if (PCWrite_HD) begin
                    r_pc <= w_pc_plus4;
                end
                if (IF_ID_write) begin
                    r_pc4   <= w_pc_plus4;
                    r_instr <= imem_instr;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign pc          = r_pc;
    assign IF_ID_pc4   = r_pc4;
    assign IF_ID_instr = r_instr;
    assign IF_ID_valid = r_valid;
    assign halted      = (r_state == ST_HALTED);
    assign cycle_cnt   = r_cycle;
    assign stall_cnt   = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage_pc_ctrl
//  Purpose  : Vector-table bench for if_stage_pc_ctrl with expected-value queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage_pc_ctrl;

    typedef struct {
        string       name;
        logic        rst;
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] imem;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halt;
        logic [15:0] e_cyc;
        logic [15:0] e_stl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcw;
    logic        ifw;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] imem;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [15:0] cyc;
    logic [15:0] stl;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    localparam logic [31:0] IA = 32'h2001_0001;
    localparam logic [31:0] IB = 32'h2002_0002;
    localparam logic [31:0] IC = 32'h0022_1820;
    localparam logic [31:0] ID = 32'hAC03_0010;
    localparam logic [31:0] IX = 32'h8C04_0000;
    localparam logic [31:0] IH = 32'hFC00_0000;

    if_stage_pc_ctrl #(
        .RESET_PC (32'h0000_0000),
        .HALT_OP  (6'b111111),
        .CNT_W    (16)
    ) dut (
        .CLK           (clk),
        .Reset         (rst),
        .PCWrite_HD    (pcw),
        .IF_ID_write   (ifw),
        .branch_taken  (br),
        .branch_target (bt),
        .jump          (j),
        .jump_target   (jt),
        .imem_instr    (imem),
        .pc            (pc),
        .IF_ID_pc4     (pc4),
        .IF_ID_instr   (instr),
        .IF_ID_valid   (valid),
        .halted        (halted),
        .cycle_cnt     (cyc),
        .stall_cnt     (stl)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string nm, logic r, logic pw, logic iw, logic b,
                                logic [31:0] btv, logic jv, logic [31:0] jtv,
                                logic [31:0] im, logic [31:0] epc, logic [31:0] epc4,
                                logic [31:0] ein, logic ev, logic eh,
                                logic [15:0] ec, logic [15:0] es);
        vec_t v;
        v.name = nm; v.rst = r; v.pcw = pw; v.ifw = iw; v.br = b; v.bt = btv;
        v.j = jv; v.jt = jtv; v.imem = im; v.e_pc = epc; v.e_pc4 = epc4;
        v.e_instr = ein; v.e_valid = ev; v.e_halt = eh; v.e_cyc = ec; v.e_stl = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Drive one vector, queue its expectation, sample after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        rst = v.rst; pcw = v.pcw; ifw = v.ifw; br = v.br; bt = v.bt;
        j = v.j; jt = v.jt; imem = v.imem;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.name, ".pc"},    pc,            e.e_pc);
        chk({e.name, ".pc4"},   pc4,           e.e_pc4);
        chk({e.name, ".instr"}, instr,         e.e_instr);
        chk({e.name, ".valid"}, {31'h0, valid},  {31'h0, e.e_valid});
        chk({e.name, ".halted"},{31'h0, halted}, {31'h0, e.e_halt});
        chk({e.name, ".cyc"},   {16'h0, cyc},  {16'h0, e.e_cyc});
        chk({e.name, ".stl"},   {16'h0, stl},  {16'h0, e.e_stl});
    endtask

    initial begin
        rst = 1'b1; pcw = 1'b1; ifw = 1'b1; br = 1'b0; bt = '0;
        j = 1'b0; jt = '0; imem = '0;

        //                 name       rst pcw ifw br bt           j  jt          imem          pc            pc4           instr  v  h  cyc      stl
        vecs.push_back(mk("reset0",   1, 1, 1, 0, 32'h0,        0, 32'h0,     32'h0, 32'h0,        32'h0,        32'h0, 0, 0, 16'd0,  16'd0));
        vecs.push_back(mk("run_a",    0, 1, 1, 0, 32'h0,        0, 32'h0,     IA,    32'h4,        32'h4,        IA,    1, 0, 16'd1,  16'd0));
        vecs.push_back(mk("run_b",    0, 1, 1, 0, 32'h0,        0, 32'h0,     IB,    32'h8,        32'h8,        IB,    1, 0, 16'd2,  16'd0));
        vecs.push_back(mk("run_c",    0, 1, 1, 0, 32'h0,        0, 32'h0,     IC,    32'hC,        32'hC,        IC,    1, 0, 16'd3,  16'd0));
        vecs.push_back(mk("run_d",    0, 1, 1, 0, 32'h0,        0, 32'h0,     ID,    32'h10,       32'h10,       ID,    1, 0, 16'd4,  16'd0));
        vecs.push_back(mk("reset1",   1, 1, 1, 0, 32'h0,        0, 32'h0,     IA,    32'h0,        32'h0,        32'h0, 0, 0, 16'd0,  16'd0));
        vecs.push_back(mk("s_a",      0, 1, 1, 0, 32'h0,        0, 32'h0,     IA,    32'h4,        32'h4,        IA,    1, 0, 16'd1,  16'd0));
        vecs.push_back(mk("s_b",      0, 1, 1, 0, 32'h0,        0, 32'h0,     IB,    32'h8,        32'h8,        IB,    1, 0, 16'd2,  16'd0));
        vecs.push_back(mk("stall1",   0, 0, 0, 0, 32'h0,        0, 32'h0,     IC,    32'h8,        32'h8,        IB,    1, 0, 16'd3,  16'd1));
        vecs.push_back(mk("stall2",   0, 0, 0, 0, 32'h0,        0, 32'h0,     IC,    32'h8,        32'h8,        IB,    1, 0, 16'd4,  16'd2));
        vecs.push_back(mk("resume",   0, 1, 1, 0, 32'h0,        0, 32'h0,     IC,    32'hC,        32'hC,        IC,    1, 0, 16'd5,  16'd2));
        vecs.push_back(mk("pc_hold",  0, 0, 1, 0, 32'h0,        0, 32'h0,     ID,    32'hC,        32'h10,       ID,    1, 0, 16'd6,  16'd2));
        vecs.push_back(mk("ifid_hold",0, 1, 0, 0, 32'h0,        0, 32'h0,     IX,    32'h10,       32'h10,       ID,    1, 0, 16'd7,  16'd3));
        vecs.push_back(mk("br_all",   0, 0, 0, 1, 32'h40,       1, 32'h200,   IX,    32'h40,       32'h0,        32'h0, 0, 0, 16'd8,  16'd3));
        vecs.push_back(mk("jump",     0, 0, 0, 0, 32'h0,        1, 32'h103,   IX,    32'h100,      32'h0,        32'h0, 0, 0, 16'd9,  16'd3));
        vecs.push_back(mk("after_j",  0, 1, 1, 0, 32'h0,        0, 32'h0,     IX,    32'h104,      32'h104,      IX,    1, 0, 16'd10, 16'd3));
        vecs.push_back(mk("br_align", 0, 1, 1, 1, 32'h203,      0, 32'h0,     IA,    32'h200,      32'h0,        32'h0, 0, 0, 16'd11, 16'd3));
        vecs.push_back(mk("f_halt",   0, 1, 1, 0, 32'h0,        0, 32'h0,     IH,    32'h204,      32'h204,      IH,    1, 0, 16'd12, 16'd3));
        vecs.push_back(mk("halt_j",   0, 1, 1, 0, 32'h0,        1, 32'h300,   IB,    32'h204,      32'h204,      IH,    1, 1, 16'd13, 16'd3));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk($sformatf("frz%0d", i), 0, 1'(i % 2), 1'(i / 3 % 2),
                              1'(i % 3 == 0), 32'h500, 1'(i % 4 == 1), 32'h600, IC,
                              32'h204, 32'h204, IH, 1, 1, 16'd13, 16'd3));
        end
        vecs.push_back(mk("rst_halt", 1, 1, 1, 0, 32'h0,        0, 32'h0,     IA,    32'h0,        32'h0,        32'h0, 0, 0, 16'd0,  16'd0));
        vecs.push_back(mk("h2_fetch", 0, 1, 1, 0, 32'h0,        0, 32'h0,     IH,    32'h4,        32'h4,        IH,    1, 0, 16'd1,  16'd0));
        vecs.push_back(mk("h2_squash",0, 1, 1, 1, 32'h80,       0, 32'h0,     IA,    32'h80,       32'h0,        32'h0, 0, 0, 16'd2,  16'd0));
        vecs.push_back(mk("h2_run",   0, 1, 1, 0, 32'h0,        0, 32'h0,     IA,    32'h84,       32'h84,       IA,    1, 0, 16'd3,  16'd0));
        vecs.push_back(mk("br_top",   0, 1, 1, 1, 32'hFFFF_FFFF,0, 32'h0,     IA,    32'hFFFF_FFFC,32'h0,        32'h0, 0, 0, 16'd4,  16'd0));
        vecs.push_back(mk("wrap",     0, 1, 1, 0, 32'h0,        0, 32'h0,     IB,    32'h0,        32'h0,        IB,    1, 0, 16'd5,  16'd0));
        vecs.push_back(mk("rst_mid",  1, 0, 0, 1, 32'h40,       1, 32'h80,    IC,    32'h0,        32'h0,        32'h0, 0, 0, 16'd0,  16'd0));

        foreach (vecs[k]) step(vecs[k]);

        // Long stall run to drive both counters into saturation.
        rst = 1'b0; pcw = 1'b0; ifw = 1'b0; br = 1'b0; j = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        step(mk("sat_stall", 0, 0, 0, 0, 32'h0, 0, 32'h0, IA,
                32'h0, 32'h0, 32'h0, 0, 0, 16'hFFFF, 16'hFFFF));
        step(mk("sat_run",   0, 1, 1, 0, 32'h0, 0, 32'h0, IA,
                32'h4, 32'h4, IA, 1, 0, 16'hFFFF, 16'hFFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
